from8bit: RTL and testbench
===========================

# from8bit

Byte-to-word reassembler sitting directly downstream of the byte serializer in the width-conversion path. It consumes the 8-bit stream on `dataIn` and rebuilds 8-, 16- or 32-bit words according to `dataS`, taking the first byte received as the most significant. Each completed word is presented on the matching output with a one-cycle `validOut` pulse. It runs on the single base (byte-rate) clock.

## Interface
- No parameters; widths are fixed at 8/16/32.
- `clk`  in  1  base byte-rate clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `enb`  in  1  block enable. Low freezes all state; no byte is accepted.
- `validIn`  in  1  `dataIn` carries a byte this cycle.
- `startIn`  in  1  marks the first byte of a word. Used only with `FROM8BIT_ALIGN_EN`.
- `dataS`  in  2  mode select: `00`/`11` = 8-bit, `01` = 16-bit, `10` = 32-bit.
- `dataIn`  in  8  input byte.
- `dataOut`  out  8  last completed 8-bit word.
- `dataOut16`  out  16  last completed 16-bit word.
- `dataOut32`  out  32  last completed 32-bit word.
- `validOut`  out  1  one-cycle pulse: a new word was written this cycle.
- `alignErr`  out  1  one-cycle pulse on a realignment. Tied to 0 without the macro.

## Operation
- A byte is accepted on a rising edge when `enb && validIn`.
- Word length N is 1 (mode 8), 2 (mode 16) or 4 (mode 32).
- Byte counter `cnt` runs 0..N-1. States:
  - IDLE: `cnt`=0, no partial word held.
  - COLLECT: `cnt`>0.
- Accepting a byte when `cnt`<N-1:
  - Shift the byte into the partial register `part[23:0]`; `part` ← {`part[15:0]`, `dataIn`}.
  - `cnt`++.
- Accepting a byte when `cnt`==N-1:
  - Assemble the word from `part` and `dataIn`, with `dataIn` as the LSB.
  - Write the word to the mode's output: `dataOut` (mode 8), `dataOut16` (mode 16) or `dataOut32` (mode 32).
  - Pulse `validOut`; `cnt`←0.
- Outputs of the other modes are not touched. All data outputs hold their value until overwritten.
- `validIn` low, or gaps between bytes: counter and partial word hold; no timeout.
- Mode change:
  - `dataS` is registered every enabled cycle into `dataS_q`.
  - If `dataS`≠`dataS_q`, the partial word is discarded and `cnt`←0.
  - A byte accepted in that same cycle counts as byte 0 of the new mode.
  - Codes `00` and `11` are the same mode, so switching between them is not a change.
- `enb` low: nothing is accepted; `validOut`=0; `cnt`, `part` and `dataS_q` hold.

## Timing
- Reset (`rst`=0): `dataOut`, `dataOut16`, `dataOut32`, `validOut`, `alignErr`, `cnt`, `part` all go to 0; `dataS_q`←`00`. Takes effect immediately, with no clock needed.
- Reset released mid-word: the partial word is lost and collection restarts at byte 0.
- Latency: the word output and `validOut` are registered and valid in the cycle after the edge that accepts byte N-1.
- Throughput: one byte per clock. Back-to-back words give a `validOut` every N cycles.
- Mode 8: `validOut` is high every cycle while bytes stream continuously.

## Configuration
- Macro: `FROM8BIT_ALIGN_EN`.
- Defined: an accepted byte with `startIn`=1 is forced to be byte 0.
  - If `cnt`≠0 at that moment, the partial word is dropped and `alignErr` pulses for one cycle, aligned with where `validOut` would appear.
  - `startIn`=1 when `cnt`=0 is normal; no error.
- Undefined: `startIn` is ignored, `alignErr` is constant 0, and framing depends only on reset and mode changes.

## Structure
- Shared package `conv8_pkg` holds:
  - Mode constants `MODE_8`=`2'b00`, `MODE_16`=`2'b01`, `MODE_32`=`2'b10`, `MODE_8B`=`2'b11`.
  - A function mapping a mode to its word length N.
  - The serializer uses the same package.
- One sub-module: `byte_cnt`.
  - 2-bit wrap counter with inputs terminal value (N-1), increment, and synchronous clear.
  - Outputs `cnt` and `last`.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0 and `validOut` stays 0; release → first accepted byte is byte 0.
- Mode 32: `dataS`=`10`, bytes AA,BB,CC,DD on consecutive cycles → `dataOut32`=AABBCCDD with `validOut` high for exactly one cycle, the cycle after DD.
- Mode 16 with gaps: `dataS`=`01`, bytes 12, (two cycles `validIn`=0), 34, (`enb`=0 for one cycle), 56, 78 → `dataOut16`=1234 then 5678, two pulses.
- Mode 8: `dataS`=`11`, stream 5A,A5 → `dataOut`=5A then A5, `validOut` high both cycles; `dataOut16`/`dataOut32` unchanged.
- Mode change mid-word: `dataS`=`10`, bytes 01,02; switch to `01` with bytes 03,04 → `dataOut16`=0304, no 32-bit pulse; mid-word `rst` pulse likewise discards the partial word.
- `FROM8BIT_ALIGN_EN`: mode 32, bytes 11,22, then 33 with `startIn`=1, then 44,55,66 → `alignErr` pulse after 33; `dataOut32`=33445566.

Source files
------------

// File: rtl/conv8_pkg.sv
// Mode codes and word-length helpers shared by the byte serializer and the
// byte-to-word reassembler.
package conv8_pkg;

   localparam logic [1:0] MODE_8  = 2'b00;
   localparam logic [1:0] MODE_16 = 2'b01;
   localparam logic [1:0] MODE_32 = 2'b10;
   localparam logic [1:0] MODE_8B = 2'b11;

   // Both 8-bit codes collapse to one mode so switching between them is not a change.
   function automatic logic [1:0] mode_norm(input logic [1:0] mode);
      return (mode == MODE_8B) ? MODE_8 : mode;
   endfunction

   function automatic logic [2:0] word_len(input logic [1:0] mode);
      case (mode_norm(mode))
         MODE_16: return 3'd2;
         MODE_32: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] mode);
      logic [2:0] n;
      n = word_len(mode) - 3'd1;
      return n[1:0];
   endfunction

endpackage

// File: rtl/from8bit_byte_cnt.sv
// 2-bit wrap counter tracking the byte position inside the word being rebuilt.
module byte_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] term,
   input  logic       inc,
   input  logic       clr,
   output logic [1:0] cnt,
   output logic       last
);

   logic [1:0] cnt_q, cnt_d, base;

   // A clear in the same cycle as an increment makes that byte position 0.
   always_comb begin
      base  = clr ? '0 : cnt_q;
      last  = (base == term);
      cnt_d = base;
      if (inc) cnt_d = last ? '0 : base + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/from8bit.sv
// Byte-to-word reassembler: first byte received is the MSB of the 8/16/32-bit word.
// Optional startIn realignment is built when FROM8BIT_ALIGN_EN is defined.
module from8bit
   import conv8_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enb,
   input  logic        validIn,
   input  logic        startIn,
   input  logic [1:0]  dataS,
   input  logic [7:0]  dataIn,
   output logic [7:0]  dataOut,
   output logic [15:0] dataOut16,
   output logic [31:0] dataOut32,
   output logic        validOut,
   output logic        alignErr
);

   logic [1:0]  dataS_q;
   logic [23:0] part_q, part_d;
   logic [7:0]  dout8_q, dout8_d;
   logic [15:0] dout16_q, dout16_d;
   logic [31:0] dout32_q, dout32_d;
   logic        valid_q, valid_d;
   logic        align_q, align_d;
   logic        acc, chg, realign, last;
   logic [1:0]  cnt;

   assign acc = enb && validIn;
   assign chg = enb && (mode_norm(dataS) != mode_norm(dataS_q));

`ifdef FROM8BIT_ALIGN_EN
   assign realign = acc && startIn;
   assign align_d = realign && !chg && (cnt != 2'd0);
`else
   logic unused_in;
   assign realign   = 1'b0;
   assign align_d   = 1'b0;
   assign unused_in = ^{cnt, startIn};
`endif

   byte_cnt u_byte_cnt (
      .clk   (clk),
      .rst_n (rst),
      .term  (last_idx(dataS)),
      .inc   (acc),
      .clr   (chg || realign),
      .cnt   (cnt),
      .last  (last)
   );

   // Stale bytes left in part after a discard are shifted out before they are used.
   always_comb begin
      part_d   = part_q;
      dout8_d  = dout8_q;
      dout16_d = dout16_q;
      dout32_d = dout32_q;
      valid_d  = 1'b0;
      if (acc) begin
         if (last) begin
            valid_d = 1'b1;
            case (mode_norm(dataS))
               MODE_16: dout16_d = {part_q[7:0], dataIn};
               MODE_32: dout32_d = {part_q, dataIn};
               default: dout8_d  = dataIn;
            endcase
         end else begin
            part_d = {part_q[15:0], dataIn};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dataS_q  <= MODE_8;
         part_q   <= '0;
         dout8_q  <= '0;
         dout16_q <= '0;
         dout32_q <= '0;
         valid_q  <= 1'b0;
         align_q  <= 1'b0;
      end else begin
         if (enb) dataS_q <= dataS;
         part_q   <= part_d;
         dout8_q  <= dout8_d;
         dout16_q <= dout16_d;
         dout32_q <= dout32_d;
         valid_q  <= valid_d;
         align_q  <= align_d;
      end
   end

   assign dataOut   = dout8_q;
   assign dataOut16 = dout16_q;
   assign dataOut32 = dout32_q;
   assign validOut  = valid_q;
   assign alignErr  = align_q;

endmodule

// File: tb/tb_from8bit.sv
// Directed plus randomized bench for from8bit against a byte-queue reference model.
module tb_from8bit;

   logic        clk = 1'b0;
   logic        rst, enb, validIn, startIn;
   logic [1:0]  dataS;
   logic [7:0]  dataIn;
   logic [7:0]  dataOut;
   logic [15:0] dataOut16;
   logic [31:0] dataOut32;
   logic        validOut, alignErr;

   int unsigned npass = 0;
   int unsigned ntot  = 0;

   logic [1:0]  m_mode;
   logic [7:0]  q[$];
   logic [7:0]  e8;
   logic [15:0] e16;
   logic [31:0] e32;
   logic        ev, ea;

   always #5 clk = ~clk;

   from8bit dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .validIn   (validIn),
      .startIn   (startIn),
      .dataS     (dataS),
      .dataIn    (dataIn),
      .dataOut   (dataOut),
      .dataOut16 (dataOut16),
      .dataOut32 (dataOut32),
      .validOut  (validOut),
      .alignErr  (alignErr)
   );

   function automatic logic [1:0] norm(input logic [1:0] s);
      return (s == 2'b11) ? 2'b00 : s;
   endfunction

   function automatic int wlen(input logic [1:0] s);
      case (norm(s))
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".validOut"},  {31'd0, validOut}, {31'd0, ev});
      chk({tag, ".alignErr"},  {31'd0, alignErr}, {31'd0, ea});
      chk({tag, ".dataOut"},   {24'd0, dataOut},  {24'd0, e8});
      chk({tag, ".dataOut16"}, {16'd0, dataOut16}, {16'd0, e16});
      chk({tag, ".dataOut32"}, dataOut32, e32);
   endtask

   task automatic model_reset();
      q.delete();
      m_mode = 2'b00;
      e8 = '0; e16 = '0; e32 = '0; ev = 1'b0; ea = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic v, input logic [1:0] s,
                             input logic [7:0] d, input logic st);
      logic [31:0] word;
      ev = 1'b0;
      ea = 1'b0;
      if (en) begin
         if (norm(s) != m_mode) q.delete();
         m_mode = norm(s);
         if (v) begin
`ifdef FROM8BIT_ALIGN_EN
            if (st && q.size() != 0) begin
               ea = 1'b1;
               q.delete();
            end
`else
            ea = ea & st;
`endif
            q.push_back(d);
            if (q.size() == wlen(s)) begin
               word = '0;
               foreach (q[i]) word = (word << 8) | {24'd0, q[i]};
               case (wlen(s))
                  2:       e16 = word[15:0];
                  4:       e32 = word;
                  default: e8  = word[7:0];
               endcase
               ev = 1'b1;
               q.delete();
            end
         end
      end
   endtask

   task automatic step(input string tag, input logic en, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic st);
      @(negedge clk);
      enb = en; validIn = v; dataS = s; dataIn = d; startIn = st;
      @(posedge clk);
      #1;
      model_step(en, v, s, d, st);
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; enb = 1'b0; validIn = 1'b0; startIn = 1'b0; dataS = 2'b00; dataIn = '0;
      model_reset();

      // Reset held with random activity on the inputs
      repeat (4) begin
         @(negedge clk);
         enb = 1'b1; validIn = 1'b1; startIn = 1'($urandom);
         dataS = 2'($urandom); dataIn = 8'($urandom);
         @(posedge clk);
         #1;
         check_all("reset_hold");
      end
      @(negedge clk);
      rst = 1'b1; enb = 1'b0; validIn = 1'b0;

      // Mode 32 back-to-back
      step("m32_b0", 1, 1, 2'b10, 8'hAA, 0);
      step("m32_b1", 1, 1, 2'b10, 8'hBB, 0);
      step("m32_b2", 1, 1, 2'b10, 8'hCC, 0);
      step("m32_b3", 1, 1, 2'b10, 8'hDD, 0);
      chk("m32_word", dataOut32, 32'hAABBCCDD);
      step("m32_idle", 1, 0, 2'b10, 8'h00, 0);

      // Mode 16 with validIn gaps and an enb-low cycle
      step("m16_12",  1, 1, 2'b01, 8'h12, 0);
      step("m16_gap", 1, 0, 2'b01, 8'hFF, 0);
      step("m16_gap", 1, 0, 2'b01, 8'hEE, 0);
      step("m16_34",  1, 1, 2'b01, 8'h34, 0);
      chk("m16_word0", {16'd0, dataOut16}, 32'h1234);
      step("m16_enb", 0, 1, 2'b01, 8'h99, 0);
      step("m16_56",  1, 1, 2'b01, 8'h56, 0);
      step("m16_78",  1, 1, 2'b01, 8'h78, 0);
      chk("m16_word1", {16'd0, dataOut16}, 32'h5678);

      // Mode 8 via the 11 code
      step("m8_5A", 1, 1, 2'b11, 8'h5A, 0);
      step("m8_A5", 1, 1, 2'b11, 8'hA5, 0);
      chk("m8_word", {24'd0, dataOut}, 32'hA5);
      step("m8_00", 1, 1, 2'b00, 8'h3C, 0);

      // Mode change mid-word discards the partial word
      step("chg_01", 1, 1, 2'b10, 8'h01, 0);
      step("chg_02", 1, 1, 2'b10, 8'h02, 0);
      step("chg_03", 1, 1, 2'b01, 8'h03, 0);
      step("chg_04", 1, 1, 2'b01, 8'h04, 0);
      chk("chg_word", {16'd0, dataOut16}, 32'h0304);

      // Asynchronous reset mid-word, observed before any clock edge
      step("rst_mid0", 1, 1, 2'b10, 8'h01, 0);
      step("rst_mid1", 1, 1, 2'b10, 8'h02, 0);
      @(negedge clk);
      enb = 1'b0; validIn = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      #1 rst = 1'b1;
      step("rst_b0", 1, 1, 2'b10, 8'h09, 0);
      step("rst_b1", 1, 1, 2'b10, 8'h0A, 0);
      step("rst_b2", 1, 1, 2'b10, 8'h0B, 0);
      step("rst_b3", 1, 1, 2'b10, 8'h0C, 0);
      chk("rst_word", dataOut32, 32'h090A0B0C);

`ifdef FROM8BIT_ALIGN_EN
      step("al_11", 1, 1, 2'b10, 8'h11, 0);
      step("al_22", 1, 1, 2'b10, 8'h22, 0);
      step("al_33", 1, 1, 2'b10, 8'h33, 1);
      chk("al_err", {31'd0, alignErr}, 32'd1);
      step("al_44", 1, 1, 2'b10, 8'h44, 0);
      step("al_55", 1, 1, 2'b10, 8'h55, 0);
      step("al_66", 1, 1, 2'b10, 8'h66, 0);
      chk("al_word", dataOut32, 32'h33445566);
`endif

      // Randomized traffic with occasional mode switches and gaps
      begin
         logic [1:0] rmode;
         rmode = 2'b10;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) rmode = 2'($urandom);
            step("rand", ($urandom_range(7) != 0), ($urandom_range(3) != 0), rmode,
                 8'($urandom), ($urandom_range(5) == 0));
         end
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
